m_wb_irqtimer: RTL and testbench



---
 rtl/m_wb_irqtimer_pkg.sv | 26 ++
 rtl/m_wb_bytewrite.sv | 48 ++++
 rtl/m_wb_irqtimer.sv | 189 ++++++++++++++++++
 tb/tb_m_wb_irqtimer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_wb_irqtimer_pkg.sv
// Shared constants for the wishbone countdown/interrupt timer: register
// indices, field bit positions and the byte-lane helper used on writes.
package m_wb_irqtimer_pkg;

    // Register select values seen on ADR_I (bus ADR[3:2])
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // CTRL field positions
    localparam int CTRL_EN           = 0;
    localparam int CTRL_AR           = 1;
    localparam int CTRL_IE           = 2;
    localparam int CTRL_PRESCALE_LSB = 8;

    // STATUS field positions
    localparam int STATUS_PEND = 0;
    localparam int STATUS_OVR  = 1;

    // Returns the SEL byte enable that governs data bit bit_idx.
    function automatic logic lane_sel(input logic [3:0] sel, input logic [4:0] bit_idx);
        return sel[bit_idx[4:3]];
    endfunction

endpackage

// File: rtl/m_wb_bytewrite.sv
// WIDTH-bit register with wishbone byte-lane write merge. A bus write always
// beats the secondary update port, so software stores take precedence over
// hardware-generated values (decrement / reload) in the same cycle.
module m_wb_bytewrite
    import m_wb_irqtimer_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_i,
    input  logic [3:0]       sel_i,
    input  logic [31:0]      dat_i,
    input  logic             upd_i,
    input  logic [WIDTH-1:0] upd_val_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    // Next value: merge enabled byte lanes on a bus write, else hardware update
    always_comb begin
        q_d = q_q;
        if (wr_i) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (lane_sel(sel_i, 5'(i))) begin
                    q_d[i] = dat_i[i];
                end
            end
        end else if (upd_i) begin
            q_d = upd_val_i;
        end
    end

    // Register storage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/m_wb_irqtimer.sv
// Wishbone-classic countdown timer with prescaler, auto-reload and a
// registered interrupt request (meip) that feeds the core's external
// interrupt input. WIDTH is expected in 8..32 and PRESCALE_W in 1..24 so the
// prescale field fits in the 32-bit CTRL word.
module m_wb_irqtimer
    import m_wb_irqtimer_pkg::*;
#(
    parameter int WIDTH                    = 32,
    parameter int PRESCALE_W               = 8,
    parameter bit DAT_O_ZERO_WHEN_INACTIVE = 1'b1
)
(
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic [1:0]  ADR_I,
    input  logic [3:0]  SEL_I,
    input  logic [31:0] DAT_I,
    output logic        ACK_O,
    output logic [31:0] DAT_O,
    output logic        meip
);

    // Handshake: STB_I is qualified by ~ACK_O so a held strobe is accepted
    // every second cycle; the access (and any write) commits at that edge.
    logic        ack_q;
    logic [31:0] dat_q;
    logic        acc;
    logic        wr;
    logic        wr_ctrl, wr_load, wr_count, wr_status;

    logic                  en_q, ar_q, ie_q;
    logic                  en_d, ar_d, ie_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  pend_q, pend_d;
    logic                  ovr_q, ovr_d;
    logic                  meip_q, meip_d;

    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] count_q;
    logic             count_zero;
    logic             tick;
    logic             expire;
    logic             ctrl_sets_en;
    logic             pend_clr, ovr_clr;
    logic             cnt_upd;
    logic [WIDTH-1:0] cnt_upd_val;
    logic [31:0]      rdata;

    assign acc       = STB_I & ~ack_q;
    assign wr        = acc & WE_I;
    assign wr_ctrl   = wr & (ADR_I == REG_CTRL);
    assign wr_load   = wr & (ADR_I == REG_LOAD);
    assign wr_count  = wr & (ADR_I == REG_COUNT);
    assign wr_status = wr & (ADR_I == REG_STATUS);

    // A tick fires when the prescaler has counted PRESCALE+1 enabled cycles.
    // A software COUNT write in the tick cycle wins and suppresses the expire.
    assign tick         = en_q & (pcnt_q == presc_q);
    assign count_zero   = (count_q == '0);
    assign expire       = tick & count_zero & ~wr_count;
    assign ctrl_sets_en = wr_ctrl & SEL_I[0] & DAT_I[CTRL_EN];
    assign pend_clr     = wr_status & SEL_I[0] & DAT_I[STATUS_PEND];
    assign ovr_clr      = wr_status & SEL_I[0] & DAT_I[STATUS_OVR];

    // Counter update: decrement when non-zero, reload old LOAD on expire with AR
    assign cnt_upd     = tick & (~count_zero | ar_q);
    assign cnt_upd_val = count_zero ? load_q : (count_q - WIDTH'(1));

    m_wb_bytewrite #(.WIDTH(WIDTH)) u_load (
        .clk_i     (CLK_I),
        .rst_i     (RST_I),
        .wr_i      (wr_load),
        .sel_i     (SEL_I),
        .dat_i     (DAT_I),
        .upd_i     (1'b0),
        .upd_val_i ('0),
        .q_o       (load_q)
    );

    m_wb_bytewrite #(.WIDTH(WIDTH)) u_count (
        .clk_i     (CLK_I),
        .rst_i     (RST_I),
        .wr_i      (wr_count),
        .sel_i     (SEL_I),
        .dat_i     (DAT_I),
        .upd_i     (cnt_upd),
        .upd_val_i (cnt_upd_val),
        .q_o       (count_q)
    );

    // Next state for CTRL, prescaler and STATUS fields
    always_comb begin
        en_d    = en_q;
        ar_d    = ar_q;
        ie_d    = ie_q;
        presc_d = presc_q;
        if (wr_ctrl) begin
            // Software CTRL write wins over an AR=0 expire clearing EN
            if (SEL_I[0]) begin
                en_d = DAT_I[CTRL_EN];
                ar_d = DAT_I[CTRL_AR];
                ie_d = DAT_I[CTRL_IE];
            end
            for (int i = 0; i < PRESCALE_W; i++) begin
                if (lane_sel(SEL_I, 5'(CTRL_PRESCALE_LSB + i))) begin
                    presc_d[i] = DAT_I[CTRL_PRESCALE_LSB + i];
                end
            end
        end else if (expire & ~ar_q) begin
            en_d = 1'b0;
        end

        if (!en_q || ctrl_sets_en || tick) begin
            pcnt_d = '0;
        end else begin
            pcnt_d = pcnt_q + PRESCALE_W'(1);
        end

        // Set beats clear for PEND; a PEND cleared this cycle does not overrun
        pend_d = (pend_q & ~pend_clr) | expire;
        ovr_d  = (ovr_q & ~ovr_clr) | (expire & pend_q & ~pend_clr);
        meip_d = pend_d & ie_d;
    end

    // Read data mux; unused bits read as zero
    always_comb begin
        rdata = '0;
        case (ADR_I)
            REG_CTRL: begin
                rdata[CTRL_EN] = en_q;
                rdata[CTRL_AR] = ar_q;
                rdata[CTRL_IE] = ie_q;
                rdata[CTRL_PRESCALE_LSB +: PRESCALE_W] = presc_q;
            end
            REG_LOAD:  rdata[WIDTH-1:0] = load_q;
            REG_COUNT: rdata[WIDTH-1:0] = count_q;
            default: begin
                rdata[STATUS_PEND] = pend_q;
                rdata[STATUS_OVR]  = ovr_q;
            end
        endcase
    end

    // Bus handshake: one-cycle ACK pulse with read data captured alongside
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= acc;
            if (acc) begin
                dat_q <= rdata;
            end else if (DAT_O_ZERO_WHEN_INACTIVE) begin
                dat_q <= '0;
            end
        end
    end

    // Timer control, prescaler, status and interrupt registers
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            ie_q    <= 1'b0;
            presc_q <= '0;
            pcnt_q  <= '0;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            meip_q  <= 1'b0;
        end else begin
            en_q    <= en_d;
            ar_q    <= ar_d;
            ie_q    <= ie_d;
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            meip_q  <= meip_d;
        end
    end

    assign ACK_O = ack_q;
    assign DAT_O = dat_q;
    assign meip  = meip_q;

endmodule

// File: tb/tb_m_wb_irqtimer.sv
// Bench for m_wb_irqtimer: directed scenarios plus randomized auto-reload
// rounds checked against an arithmetic model of tick/expire timing.
module tb_m_wb_irqtimer;

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_LOAD   = 2'd1;
  localparam logic [1:0] A_COUNT  = 2'd2;
  localparam logic [1:0] A_STATUS = 2'd3;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        stb, we;
  logic [1:0]  adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic        ack;
  logic [31:0] dat_o;
  logic        meip;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int last_edge;
  logic [31:0] last_rd;
  logic last_ack;
  logic last_meip;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  m_wb_irqtimer dut (
    .CLK_I (clk),
    .RST_I (rst),
    .STB_I (stb),
    .WE_I  (we),
    .ADR_I (adr),
    .SEL_I (sel),
    .DAT_I (dat_i),
    .ACK_O (ack),
    .DAT_O (dat_o),
    .meip  (meip)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  // Ticks land at E0 + m*(P+1); with start count c the first expire is tick
  // c+1, then one every L+1 ticks.
  function automatic int model_count(input int c, input int l, input int k);
    if (k <= c) return c - k;
    return l - ((k - c - 1) % (l + 1));
  endfunction

  function automatic int model_nexp(input int c, input int l, input int k);
    if (k <= c) return 0;
    return 1 + (k - c - 1) / (l + 1);
  endfunction

  // ---------------- driver tasks ----------------
  // Entered at a negedge with ACK low; commits at the next posedge and
  // returns at a negedge after ACK has dropped again.
  task automatic wb_access(input logic w, input logic [1:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
    @(posedge clk); @(negedge clk);
    last_edge = cyc; last_rd = dat_o; last_ack = ack; last_meip = meip;
    stb = 1'b0; we = 1'b0; sel = 4'h0; dat_i = '0;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    wb_access(1'b1, a, d, s);
  endtask

  task automatic wb_read(input logic [1:0] a);
    wb_access(1'b0, a, 32'h0, 4'hF);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
    checks++;
    if (cyc != n) begin
      failures++;
      $display("FAIL sched: at cycle %0d, required %0d", cyc, n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; stb = 1'b0; we = 1'b0; adr = '0; sel = '0; dat_i = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack, meip, dat_o} !== 34'h0) begin
      failures++;
      $display("FAIL reset_outputs: ack=%b meip=%b dat=%h, required 0/0/0", ack, meip, dat_o);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int r = 0; r < 4; r++) begin
      wb_read(2'(r));
      checks++;
      if (last_ack !== 1'b1 || last_rd !== 32'h0 || last_meip !== 1'b0) begin
        failures++;
        $display("FAIL reset_read%0d: ack=%b dat=%h meip=%b, required 1/00000000/0",
                 r, last_ack, last_rd, last_meip);
      end
    end
  endtask

  task automatic test_autoreload();
    int e0;
    wb_write(A_LOAD, 32'd5, 4'hF);
    wb_write(A_CTRL, 32'h7, 4'hF);
    e0 = last_edge;
    checks++;
    if (last_meip !== 1'b0 || meip !== 1'b1) begin
      failures++;
      $display("FAIL ar_first_expire: meip at enable=%b next=%b, required 0,1", last_meip, meip);
    end
    wb_write(A_STATUS, 32'h1, 4'hF);           // commits e0+2
    checks++;
    if (last_meip !== 1'b0) begin
      failures++;
      $display("FAIL ar_w1c_meip: meip=%b, required 0", last_meip);
    end
    wb_read(A_COUNT);                          // commits e0+4
    checks++;
    if (last_rd !== 32'(model_count(0, 5, last_edge - 1 - e0))) begin
      failures++;
      $display("FAIL ar_count: got %h, required %h", last_rd, model_count(0, 5, last_edge - 1 - e0));
    end
    wait_until(e0 + 6);
    checks++;
    if (meip !== 1'b0) begin
      failures++;
      $display("FAIL ar_pre_second: meip=%b, required 0", meip);
    end
    @(negedge clk);
    checks++;
    if (meip !== 1'b1) begin
      failures++;
      $display("FAIL ar_second_expire: meip=%b, required 1", meip);
    end
    wait_until(e0 + 13);
    wb_read(A_STATUS);                         // commits e0+14
    checks++;
    if (last_rd !== 32'h3) begin
      failures++;
      $display("FAIL ar_overrun: status=%h, required 00000003", last_rd);
    end
    wb_write(A_STATUS, 32'h2, 4'hF);           // clear OVR only, e0+16
    wait_until(e0 + 18);
    wb_write(A_STATUS, 32'h1, 4'hF);           // W1C PEND on expire edge e0+19
    wb_read(A_STATUS);
    checks++;
    if (last_rd !== 32'h1 || last_meip !== 1'b1) begin
      failures++;
      $display("FAIL ar_w1c_on_expire: status=%h meip=%b, required 00000001/1", last_rd, last_meip);
    end
    wb_write(A_CTRL, 32'h0, 4'hF);
    wb_write(A_STATUS, 32'h3, 4'hF);
  endtask

  task automatic test_oneshot();
    int e0;
    wb_write(A_COUNT, 32'd2, 4'hF);
    wb_write(A_CTRL, 32'h0301, 4'hF);
    e0 = last_edge;
    wait_until(e0 + 11);
    wb_read(A_STATUS);                         // value before expire edge e0+12
    checks++;
    if (last_rd !== 32'h0) begin
      failures++;
      $display("FAIL os_before_expire: status=%h, required 00000000", last_rd);
    end
    wb_read(A_STATUS);
    checks++;
    if (last_rd !== 32'h1) begin
      failures++;
      $display("FAIL os_pend: status=%h, required 00000001", last_rd);
    end
    wb_read(A_CTRL);
    checks++;
    if (last_rd !== 32'h0300) begin
      failures++;
      $display("FAIL os_ctrl: ctrl=%h, required 00000300", last_rd);
    end
    repeat (10) @(negedge clk);
    wb_read(A_COUNT);
    checks++;
    if (last_rd !== 32'h0 || last_meip !== 1'b0) begin
      failures++;
      $display("FAIL os_count: count=%h meip=%b, required 00000000/0", last_rd, last_meip);
    end
  endtask

  task automatic test_bytewrite();
    wb_write(A_LOAD, 32'h11223344, 4'hF);
    wb_write(A_LOAD, 32'h00AB0000, 4'b0100);
    wb_read(A_LOAD);
    checks++;
    if (last_rd !== 32'h11AB3344) begin
      failures++;
      $display("FAIL byte_load: got %h, required 11AB3344", last_rd);
    end
    wb_write(A_CTRL, 32'h000005FF, 4'b0010);
    wb_read(A_CTRL);
    checks++;
    if (last_rd !== 32'h00000500) begin
      failures++;
      $display("FAIL byte_ctrl: got %h, required 00000500", last_rd);
    end
    wb_write(A_STATUS, 32'h1, 4'b0010);        // SEL[0]=0: no clear
    wb_read(A_STATUS);
    checks++;
    if (last_rd !== 32'h1) begin
      failures++;
      $display("FAIL byte_status_nosel: got %h, required 00000001", last_rd);
    end
    wb_write(A_STATUS, 32'h1, 4'b0001);
    wb_read(A_STATUS);
    checks++;
    if (last_rd !== 32'h0) begin
      failures++;
      $display("FAIL byte_status_sel: got %h, required 00000000", last_rd);
    end
    wb_write(A_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_hold_stb();
    logic [3:0] pat;
    logic [31:0] d1, d2;
    stb = 1'b1; we = 1'b0; adr = A_LOAD; sel = 4'hF;
    pat[3] = ack;
    @(posedge clk); @(negedge clk); pat[2] = ack; d1 = dat_o;
    @(posedge clk); @(negedge clk); pat[1] = ack; d2 = dat_o;
    @(posedge clk); @(negedge clk); pat[0] = ack;
    stb = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (pat !== 4'b0101) begin
      failures++;
      $display("FAIL hold_ack_pattern: got %b, required 0101", pat);
    end
    checks++;
    if (d1 !== 32'h11AB3344 || d2 !== 32'h0) begin
      failures++;
      $display("FAIL hold_dat: active=%h idle=%h, required 11AB3344/00000000", d1, d2);
    end
  endtask

  task automatic test_reset_midwrite();
    stb = 1'b1; we = 1'b0; adr = A_LOAD; sel = 4'hF;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (ack !== 1'b0 || dat_o !== 32'h0) begin
      failures++;
      $display("FAIL rst_async_ack: ack=%b dat=%h, required 0/00000000", ack, dat_o);
    end
    we = 1'b1; dat_i = 32'hDEADBEEF;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; stb = 1'b0; we = 1'b0; dat_i = '0;
    @(posedge clk); @(negedge clk);
    wb_read(A_LOAD);
    checks++;
    if (last_rd !== 32'h0) begin
      failures++;
      $display("FAIL rst_no_write: load=%h, required 00000000", last_rd);
    end
    wb_write(A_LOAD, 32'hCAFE0123, 4'hF);
    wb_read(A_LOAD);
    checks++;
    if (last_rd !== 32'hCAFE0123) begin
      failures++;
      $display("FAIL rst_retry: load=%h, required CAFE0123", last_rd);
    end
  endtask

  task automatic test_random();
    int l, c, p, ie, w, e0, k, n;
    logic [31:0] exp_v;
    for (int r = 0; r < 8; r++) begin
      l = $urandom_range(0, 20); c = $urandom_range(0, 10);
      p = $urandom_range(0, 3);  ie = $urandom_range(0, 1); w = $urandom_range(0, 60);
      wb_write(A_CTRL, 32'h0, 4'hF);
      wb_write(A_STATUS, 32'h3, 4'hF);
      wb_write(A_LOAD, 32'(l), 4'hF);
      wb_write(A_COUNT, 32'(c), 4'hF);
      wb_write(A_CTRL, 32'((p << 8) | (ie << 2) | 3), 4'hF);
      e0 = last_edge;
      repeat (w) @(negedge clk);
      wb_read(A_COUNT);
      k = (last_edge - 1 - e0) / (p + 1);
      exp_v = 32'(model_count(c, l, k));
      checks++;
      if (last_rd !== exp_v) begin
        failures++;
        $display("FAIL rnd_count r%0d: got %h, required %h (L=%0d c=%0d P=%0d)", r, last_rd, exp_v, l, c, p);
      end
      wb_read(A_STATUS);
      n = model_nexp(c, l, (last_edge - 1 - e0) / (p + 1));
      exp_v = {30'h0, n >= 2, n >= 1};
      checks++;
      if (last_rd !== exp_v) begin
        failures++;
        $display("FAIL rnd_status r%0d: got %h, required %h", r, last_rd, exp_v);
      end
      n = model_nexp(c, l, (last_edge - e0) / (p + 1));
      checks++;
      if (last_meip !== ((ie != 0) && (n >= 1))) begin
        failures++;
        $display("FAIL rnd_meip r%0d: got %b, required %b", r, last_meip, ((ie != 0) && (n >= 1)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_autoreload();
    test_oneshot();
    test_bytewrite();
    test_hold_stb();
    test_reset_midwrite();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
